// File: rtl/gray_codec_pkg.sv
// Shared types and chunk-geometry helpers for the pipelined Gray/binary codec.
package gray_codec_pkg;

  typedef enum logic {G2B = 1'b0, B2G = 1'b1} codec_mode_e;

  function automatic int chunk_width(input int data_width, input int stages);
    return (data_width + stages - 1) / stages;
  endfunction

  // Low bit of stage s's chunk; trailing chunks may run past bit 0.
  function automatic int chunk_lo(input int s, input int data_width, input int stages);
    int lo;
    lo = data_width - (s + 1) * chunk_width(data_width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline stage: resolves its chunk of the Gray-to-binary prefix XOR and
// holds the valid/mode/data registers for the word it carries.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGE_IDX  = 0,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  ld,
  input  logic                  adv,
  input  logic                  up_mode,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  valid,
  output logic                  mode,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int CW = chunk_width(DATA_WIDTH, STAGES);
  localparam int HI = DATA_WIDTH - 1 - STAGE_IDX * CW;

  logic [DATA_WIDTH-1:0] conv;
  logic                  valid_q, valid_d, mode_q, mode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  if (HI >= 0) begin : g_chain
    localparam int LO   = chunk_lo(STAGE_IDX, DATA_WIDTH, STAGES);
    localparam int SEED = (STAGE_IDX == 0) ? 0 : HI + 1;
    logic acc;

    // Bits above HI are already binary, so bit HI+1 seeds this chunk.
    always_comb begin
      conv = up_data;
      acc  = (STAGE_IDX == 0) ? 1'b0 : up_data[SEED];
      if (up_mode == G2B) begin
        for (int i = HI; i >= LO; i--) begin
          acc     = acc ^ up_data[i];
          conv[i] = acc;
        end
      end
    end
  end else begin : g_pass
    assign conv = up_data;
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (ld) begin
      valid_d = 1'b1;
      mode_d  = up_mode;
      data_d  = conv;
    end else if (adv) begin
      valid_d = 1'b0;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign mode  = mode_q;
  assign data  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with valid/ready on both sides; the
// direction travels with each word so mixed-mode streams need no bubbles.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_mode,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int CNT_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]                 vld, mde, adv, ld;
  logic [STAGES-1:0][DATA_WIDTH-1:0] dat;
  logic [DATA_WIDTH-1:0]             in_conv;
  logic                              in_acc;
  logic [CNT_W-1:0]                  count_q, count_d;

  // Ready ripples back from out_ready so a full pipe can move every cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = vld[STAGES-1] & out_ready;
    for (int s = STAGES - 2; s >= 0; s--)
      adv[s] = vld[s] & (~vld[s+1] | adv[s+1]);
  end

  assign in_ready = ~vld[0] | adv[0];
  assign in_acc   = in_valid & in_ready & ~flush;
  assign in_conv  = in_mode ? (in_data ^ (in_data >> 1)) : in_data;

  always_comb begin
    ld    = adv << 1;
    ld[0] = in_acc;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic                  up_mode;
    logic [DATA_WIDTH-1:0] up_data;
    if (s == 0) begin : g_head
      assign up_mode = in_mode;
      assign up_data = in_conv;
    end else begin : g_body
      assign up_mode = mde[s-1];
      assign up_data = dat[s-1];
    end

    gray_codec_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGE_IDX  (s),
      .STAGES     (STAGES)
    ) u_stage (
      .clk     (clk),
      .resetn  (resetn),
      .flush   (flush),
      .ld      (ld[s]),
      .adv     (adv[s]),
      .up_mode (up_mode),
      .up_data (up_data),
      .valid   (vld[s]),
      .mode    (mde[s]),
      .data    (dat[s])
    );
  end

  always_comb begin
    count_d = count_q + CNT_W'(in_acc) - CNT_W'(adv[STAGES-1]);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count     = count_q;
  assign out_valid = vld[STAGES-1];
  assign out_mode  = mde[STAGES-1];
  assign out_data  = dat[STAGES-1];

endmodule
